// File: rtl/ifq_pkg.sv
// Shared types and width helpers for the instruction fetch queue.
// Default configuration values used by ifq_multi_line and ifq_line_ram.
package ifq_pkg;

  typedef enum logic [1:0] {
    IFQ_IDLE = 2'd0,
    IFQ_WAIT = 2'd1,
    IFQ_DROP = 2'd2
  } ifq_state_e;

  localparam int          IFQ_XLEN       = 32;
  localparam int          IFQ_LINE_WORDS = 4;
  localparam int          IFQ_DEPTH      = 4;
  localparam logic [31:0] IFQ_RESET_PC   = 32'h0040_0000;

  // Derived widths, computed from whatever configuration the instantiating module uses
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int line_w(input int line_words);
    return 32 * line_words;
  endfunction

  function automatic int line_bytes(input int line_words);
    return 4 * line_words;
  endfunction

endpackage

// File: rtl/ifq_line_ram.sv
// Line storage for the fetch queue: one write port, one asynchronous read port.
// Each entry holds the line data and the line base PC. There is no reset on the contents.
module ifq_line_ram #(
  parameter int XLEN   = 32,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [XLEN-1:0]   wbase,
  input  logic [PTR_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata,
  output logic [XLEN-1:0]   rbase
);

  logic [LINE_W-1:0] data_q [DEPTH];
  logic [XLEN-1:0]   base_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      data_q[waddr] <= wdata;
      base_q[waddr] <= wbase;
    end
  end

  assign rdata = data_q[raddr];
  assign rbase = base_q[raddr];

endmodule

// File: rtl/ifq_multi_line.sv
// Instruction fetch queue: fetches whole I-cache lines, hands one instruction per cycle to dispatch.
// Optional macro IFQ_STATS_EN adds the stat_full_cyc / stat_flush counter ports.
//
// state    | meaning
// IFQ_IDLE | no request outstanding; issue when a slot is free and no redirect
// IFQ_WAIT | request outstanding; response is written into the queue
// IFQ_DROP | request outstanding but made stale by a redirect; response is discarded
module ifq_multi_line
  import ifq_pkg::*;
#(
  parameter int              XLEN       = IFQ_XLEN,
  parameter int              LINE_WORDS = IFQ_LINE_WORDS,
  parameter int              DEPTH      = IFQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC   = IFQ_RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ic_req,
  output logic [XLEN-1:0]         ic_addr,
  input  logic                    ic_rsp_valid,
  input  logic [32*LINE_WORDS-1:0] ic_rsp_data,
  input  logic                    br_valid,
  input  logic [XLEN-1:0]         br_target,
  output logic                    inst_valid,
  output logic [31:0]             inst,
  output logic [XLEN-1:0]         inst_pc,
  input  logic                    inst_ready,
  output logic                    ifq_empty,
  output logic                    ifq_full
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]             stat_full_cyc,
  output logic [31:0]             stat_flush
`endif
);

  localparam int              OW        = off_w(LINE_WORDS);
  localparam int              PW        = ptr_w(DEPTH);
  localparam int              LW        = line_w(LINE_WORDS);
  localparam logic [XLEN-1:0] STRIDE    = XLEN'(line_bytes(LINE_WORDS));
  localparam logic [XLEN-1:0] LINE_MASK = ~(STRIDE - XLEN'(1));
  localparam logic [PW:0]     FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [OW-1:0]   LAST_OFF  = OW'(LINE_WORDS - 1);

  ifq_state_e       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]    rd_off_q, rd_off_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;

  logic             wr_en, accept, pop;
  logic [LW-1:0]    head_data;
  logic [XLEN-1:0]  head_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IFQ_IDLE;
    else     state_q <= state_d;
  end

  // A response arriving together with a redirect settles the outstanding request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IFQ_IDLE: if (ic_req) state_d = IFQ_WAIT;
      IFQ_WAIT: begin
        if (ic_rsp_valid)  state_d = IFQ_IDLE;
        else if (br_valid) state_d = IFQ_DROP;
      end
      IFQ_DROP: if (ic_rsp_valid) state_d = IFQ_IDLE;
      default:  state_d = IFQ_IDLE;
    endcase
  end

  always_comb begin
    ic_req  = !rst && (state_q == IFQ_IDLE) && (count_q < FULL_CNT) && !br_valid;
    ic_addr = fetch_pc_q;
  end

  always_comb begin
    wr_en      = (state_q == IFQ_WAIT) && ic_rsp_valid && !br_valid;
    inst_valid = (count_q != '0);
    accept     = inst_valid && inst_ready && !br_valid;
    pop        = accept && (rd_off_q == LAST_OFF);
    ifq_empty  = (count_q == '0);
    ifq_full   = (count_q == FULL_CNT);
    inst       = head_data[32*rd_off_q +: 32];
    inst_pc    = head_base + XLEN'({rd_off_q, 2'b00});
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_off_d   = rd_off_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (br_valid) begin
      fetch_pc_d = br_target & LINE_MASK;
      rd_off_d   = br_target[OW+1:2];
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + STRIDE;
      end
      // rd_off wraps to zero on its own when the last word of a line is taken
      if (accept) rd_off_d = rd_off_q + OW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(wr_en) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC & LINE_MASK;
      rd_off_q   <= RESET_PC[OW+1:2];
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_off_q   <= rd_off_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  ifq_line_ram #(
    .XLEN   (XLEN),
    .LINE_W (LW),
    .DEPTH  (DEPTH),
    .PTR_W  (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (ic_rsp_data),
    .wbase (fetch_pc_q),
    .raddr (rd_ptr_q),
    .rdata (head_data),
    .rbase (head_base)
  );

`ifdef IFQ_STATS_EN
  logic [31:0] full_cyc_q, full_cyc_d;
  logic [31:0] flush_q, flush_d;

  always_comb begin
    full_cyc_d = full_cyc_q;
    flush_d    = flush_q;
    if (ifq_full && (full_cyc_q != '1)) full_cyc_d = full_cyc_q + 32'd1;
    if (br_valid && (flush_q != '1))    flush_d    = flush_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cyc_q <= '0;
      flush_q    <= '0;
    end else begin
      full_cyc_q <= full_cyc_d;
      flush_q    <= flush_d;
    end
  end

  assign stat_full_cyc = full_cyc_q;
  assign stat_flush    = flush_q;
`endif

endmodule
